// File: rtl/if_stage.sv
// Instruction fetch: pre-IF next-PC generation, sync SRAM fetch, {inst, pc} to decode.
// Latency: 1 cycle request-to-offer; on decode stall the fetched word is buffered and no new request issues.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic        r_to_fs_valid;
    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic        r_buf_valid;
    logic        r_rdata_fresh;
    logic [31:0] r_inst_buf;

    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic [31:0] w_seq_pc;
    logic [31:0] w_nextpc;
    logic        w_fs_ready_go;
    logic        w_fs_allowin;
    logic        w_req;
    logic        w_capture;
    logic [31:0] w_fs_inst;

    assign w_br_taken    = br_bus[32];
    assign w_br_target   = br_bus[31:0];
    assign w_seq_pc      = r_fs_pc + 32'd4;
    assign w_nextpc      = w_br_taken ? w_br_target : w_seq_pc;
    assign w_fs_ready_go = 1'b1;
    assign w_fs_allowin  = !r_fs_valid || (w_fs_ready_go && ds_allowin);

    // A taken branch forces a fetch even when decode is stalled.
    assign w_req     = r_to_fs_valid && (w_fs_allowin || w_br_taken);
    // SRAM data lives for one cycle only; keep it if decode cannot take it yet.
    assign w_capture = r_rdata_fresh && r_fs_valid && !ds_allowin && !w_br_taken;
    assign w_fs_inst = r_buf_valid ? r_inst_buf : inst_sram_rdata;

    assign fs_to_ds_valid  = r_fs_valid && w_fs_ready_go && !w_br_taken;
    assign fs_to_ds_bus    = {w_fs_inst, r_fs_pc};
    assign inst_sram_en    = w_req;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_addr  = w_nextpc;
    assign inst_sram_wdata = 32'h0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_fs_valid <= 1'b0;
            r_fs_valid    <= 1'b0;
            r_fs_pc       <= RESET_PC - 32'd4;
            r_buf_valid   <= 1'b0;
            r_rdata_fresh <= 1'b0;
            r_inst_buf    <= 32'h0;
        end else begin
            r_to_fs_valid <= 1'b1;
            if (w_req) begin
                r_fs_valid    <= 1'b1;
                r_fs_pc       <= w_nextpc;
                r_rdata_fresh <= 1'b1;
                r_buf_valid   <= 1'b0;
            end else begin
                r_rdata_fresh <= 1'b0;
                if (r_fs_valid && ds_allowin)
                    r_fs_valid <= 1'b0;
                if (w_capture) begin
                    r_inst_buf  <= inst_sram_rdata;
                    r_buf_valid <= 1'b1;
                end else if (ds_allowin) begin
                    r_buf_valid <= 1'b0;
                end
            end
        end
    end

endmodule
